tmds_rx_decode: RTL

Single-channel TMDS receive decoder for the HDMI/DVI sink path: the counterpart of the transmit-side `encode` plus serializer on one data lane. It accepts unaligned 10-bit words from a 1:10 deserializer. It finds word alignment using control-token runs and drives a bitslip pulse back to the deserializer. It decodes aligned words into video data, control bits or TERC4 auxiliary nibbles. Three instances (blue, green, red) sit between the deserializers and the receiver top level.

---
 rtl/tmds_pkg.sv | 71 +++++++
 rtl/tmds_word_align.sv | 87 ++++++++
 rtl/tmds_rx_decode.sv | 95 +++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS symbol definitions: control tokens, TERC4 table and the 8b decode.
// The transmit encoder imports this same package so both directions agree.
package tmds_pkg;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // Index i holds the code the encoder emits for nibble i.
    localparam logic [9:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED
    } align_state_t;

    function automatic logic is_ctrl(input logic [9:0] w);
        return w inside {CTRL_00, CTRL_01, CTRL_10, CTRL_11};
    endfunction

    // Returns {c1, c0}; only meaningful when is_ctrl(w) holds.
    function automatic logic [1:0] ctrl_bits(input logic [9:0] w);
        logic [1:0] c;
        case (w)
            CTRL_00: c = 2'b00;
            CTRL_01: c = 2'b01;
            CTRL_10: c = 2'b10;
            default: c = 2'b11;
        endcase
        return c;
    endfunction

    function automatic logic is_terc4(input logic [9:0] w);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (w == TERC4_CODE[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [3:0] terc4_index(input logic [9:0] w);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (w == TERC4_CODE[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8 selects XOR).
    function automatic logic [7:0] decode8(input logic [9:0] w);
        logic [7:0] x;
        logic [7:0] d;
        x    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = x[0];
        for (int unsigned i = 1; i < 8; i++) begin
            d[i] = x[i] ^ x[i-1] ^ ~w[8];
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_word_align.sv
// Word-alignment FSM: counts control-token runs and pulses bitslip until the
// lane shows LOCK_TOKENS consecutive tokens; drops lock on a token drought.
module tmds_word_align #(
    parameter int unsigned LOCK_TOKENS = 8,
    parameter int unsigned TIMEOUT_W   = 16,
    parameter int unsigned SLIP_WAIT   = 4
) (
    input  logic pix_clk,
    input  logic rst_n,
    input  logic ctrl_seen,
    output logic bitslip,
    output logic aligned
);
    import tmds_pkg::*;

    localparam int unsigned TOK_W  = $clog2(LOCK_TOKENS + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam logic [TOK_W-1:0]  TOK_LOCK  = TOK_W'(LOCK_TOKENS);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    align_state_t         state;
    logic [TOK_W-1:0]     tok_cnt;
    logic [TOK_W-1:0]     tok_nxt;
    logic [TIMEOUT_W-1:0] timer;
    logic [TIMEOUT_W-1:0] timer_nxt;
    logic [WAIT_W-1:0]    wait_cnt;

    always_comb begin
        timer_nxt = (&timer) ? timer : timer + TIMEOUT_W'(1);
        tok_nxt   = '0;
        if (ctrl_seen) tok_nxt = (tok_cnt == TOK_LOCK) ? tok_cnt : tok_cnt + TOK_W'(1);
    end

    // Timeouts fire on the increment that reaches all-ones; lock and token arrival take priority.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SEARCH;
            tok_cnt  <= '0;
            timer    <= '0;
            wait_cnt <= '0;
            bitslip  <= 1'b0;
            aligned  <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            case (state)
                ST_SEARCH: begin
                    tok_cnt <= tok_nxt;
                    if (tok_nxt == TOK_LOCK) begin
                        state   <= ST_LOCKED;
                        aligned <= 1'b1;
                        timer   <= '0;
                    end else if (&timer_nxt) begin
                        state   <= ST_SLIP;
                        bitslip <= 1'b1;
                        timer   <= timer_nxt;
                    end else begin
                        timer <= timer_nxt;
                    end
                end
                ST_SLIP: begin
                    state    <= ST_WAIT;
                    timer    <= '0;
                    tok_cnt  <= '0;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) state <= ST_SEARCH;
                    else                       wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                ST_LOCKED: begin
                    if (ctrl_seen) begin
                        timer <= '0;
                    end else if (&timer_nxt) begin
                        state   <= ST_SEARCH;
                        aligned <= 1'b0;
                        tok_cnt <= '0;
                        timer   <= '0;
                    end else begin
                        timer <= timer_nxt;
                    end
                end
                default: state <= ST_SEARCH;
            endcase
        end
    end

endmodule

// File: rtl/tmds_rx_decode.sv
// Single-lane TMDS receive decoder: stage-1 word register, alignment FSM,
// and a registered control / TERC4 / video decode at stage 2.
module tmds_rx_decode #(
    parameter string       MODE        = "DVI",
    parameter int unsigned LOCK_TOKENS = 8,
    parameter int unsigned TIMEOUT_W   = 16,
    parameter int unsigned SLIP_WAIT   = 4
) (
    input  logic       pix_clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       island,
    output logic       bitslip,
    output logic       aligned,
    output logic [7:0] vdout,
    output logic [3:0] adout,
    output logic       c0,
    output logic       c1,
    output logic       vde,
    output logic       ade
);
    import tmds_pkg::*;

    localparam bit HDMI_EN = (MODE == "HDMI");

    logic [9:0] s1_din;
    logic       s1_island;
    logic       s1_ctrl;
    logic       vde_n;
    logic       ade_n;
    logic [7:0] vd_n;
    logic [3:0] ad_n;
    logic [1:0] c_n;

    // Island context travels with its word so both reach the decoder together.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_din    <= '0;
            s1_island <= 1'b0;
        end else begin
            s1_din    <= din;
            s1_island <= island;
        end
    end

    assign s1_ctrl = is_ctrl(s1_din);

    tmds_word_align #(
        .LOCK_TOKENS(LOCK_TOKENS),
        .TIMEOUT_W  (TIMEOUT_W),
        .SLIP_WAIT  (SLIP_WAIT)
    ) u_align (
        .pix_clk  (pix_clk),
        .rst_n    (rst_n),
        .ctrl_seen(s1_ctrl),
        .bitslip  (bitslip),
        .aligned  (aligned)
    );

    always_comb begin
        vde_n = 1'b1;
        ade_n = 1'b0;
        vd_n  = decode8(s1_din);
        ad_n  = adout;
        c_n   = {c1, c0};
        if (s1_ctrl) begin
            vde_n = 1'b0;
            vd_n  = vdout;
            c_n   = ctrl_bits(s1_din);
        end else if (HDMI_EN && s1_island && is_terc4(s1_din)) begin
            vde_n = 1'b0;
            ade_n = 1'b1;
            vd_n  = vdout;
            ad_n  = terc4_index(s1_din);
        end
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            vdout <= '0;
            adout <= '0;
            c0    <= 1'b0;
            c1    <= 1'b0;
            vde   <= 1'b0;
            ade   <= 1'b0;
        end else begin
            vdout <= vd_n;
            adout <= ad_n;
            {c1, c0} <= c_n;
            vde   <= vde_n;
            ade   <= ade_n;
        end
    end

endmodule
